johnson_decode_monitor: RTL and testbench

- Downstream consumer of the 4-bit up/down Johnson counter output.
- Decodes each sampled Johnson code into a binary index and checks that successive codes are legal single steps.
- Tracks step direction and a signed net-position accumulator.
- Flags illegal codes and sequence errors for the system error/status logic.

---
 rtl/johnson_pkg.sv | 23 ++
 rtl/johnson_decode.sv | 51 +++++
 rtl/johnson_decode_monitor.sv | 170 +++++++++++++++++
 tb/tb_johnson_decode_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
`default_nettype none
// ============================================================================
// Module      : johnson_pkg
// Description : Shared state encoding and width helper for the Johnson
//               code decoder / sequence monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package johnson_pkg;

   localparam int STATE_W = 2;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_INIT  = 2'd0;
   localparam state_t ST_TRACK = 2'd1;
   localparam state_t ST_ERR   = 2'd2;

   // Index width needed to number all 2*width states of a width-bit code.
   function automatic int idx_w(input int width);
      return $clog2(2 * width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_decode.sv
`default_nettype none
// ============================================================================
// Module      : johnson_decode
// Description : Combinational Johnson code to binary index decoder with a
//               legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_decode
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDX_W = idx_w(WIDTH)
)(
   input  logic [WIDTH-1:0] code_i,
   output logic [IDX_W-1:0] index_o,
   output logic             legal_o
);

   int               pop;
   logic [WIDTH-1:0] mask_lo;
   logic [WIDTH-1:0] mask_hi;

   // A legal code is a run of ones anchored at bit 0 (filling half) or
   // anchored at the MSB (draining half); popcount then gives the index.
   always_comb begin
      pop     = 0;
      mask_lo = '0;
      mask_hi = '0;
      index_o = '0;
      legal_o = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (code_i[i]) pop++;
      end
      for (int i = 0; i < WIDTH; i++) begin
         mask_lo[i] = (i < pop);
         mask_hi[i] = (i >= WIDTH - pop);
      end
      if (code_i == '0) begin
         index_o = '0;
         legal_o = 1'b1;
      end else if (code_i[0]) begin
         index_o = IDX_W'(pop);
         legal_o = (code_i == mask_lo);
      end else begin
         index_o = IDX_W'(2 * WIDTH - pop);
         legal_o = (code_i == mask_hi);
      end
   end

endmodule
`default_nettype wire

// File: rtl/johnson_decode_monitor.sv
`default_nettype none
// ============================================================================
// Module      : johnson_decode_monitor
// Description : Tracks a sampled Johnson counter, reporting index, step
//               direction, net position and illegal / sequence errors.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_decode_monitor
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8,
   parameter int IDX_W = idx_w(WIDTH)
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear_err,
   input  logic [WIDTH-1:0] code_in,
   output logic [IDX_W-1:0] index_out,
   output logic             valid,
   output logic             dir,
   output logic             step,
   output logic             illegal,
   output logic             seq_err,
   output logic [CNT_W-1:0] position
);

   localparam int NSTATES = 2 * WIDTH;

   state_t           state_q,   state_d;
   logic [IDX_W-1:0] index_q,   index_d;
   logic             valid_q,   valid_d;
   logic             dir_q,     dir_d;
   logic             step_q,    step_d;
   logic             illegal_q, illegal_d;
   logic             seq_err_q, seq_err_d;
   logic [CNT_W-1:0] pos_q,     pos_d;

   logic [IDX_W-1:0] w_idx;
   logic             w_legal;
   logic [IDX_W:0]   w_delta;
   logic             w_same;
   logic             w_fwd;
   logic             w_bwd;

   johnson_decode #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_decode (
      .code_i  (code_in),
      .index_o (w_idx),
      .legal_o (w_legal)
   );

   // Modular distance from the last accepted index; NSTATES need not be a
   // power of two, so the wrap is added explicitly.
   always_comb begin
      w_delta = {1'b0, w_idx} - {1'b0, index_q};
      if (w_idx < index_q) w_delta = w_delta + (IDX_W+1)'(NSTATES);
   end

   assign w_same = (w_delta == '0);
   assign w_fwd  = (w_delta == (IDX_W+1)'(1));
   assign w_bwd  = (w_delta == (IDX_W+1)'(NSTATES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: begin
            if (enable && w_legal) state_d = ST_TRACK;
         end
         ST_TRACK: begin
            if (enable && (!w_legal || !(w_same || w_fwd || w_bwd))) state_d = ST_ERR;
         end
         ST_ERR: begin
            if (clear_err) state_d = ST_INIT;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_comb begin
      index_d   = index_q;
      valid_d   = valid_q;
      dir_d     = dir_q;
      step_d    = 1'b0;
      illegal_d = 1'b0;
      seq_err_d = seq_err_q;
      pos_d     = pos_q;
      case (state_q)
         ST_INIT: begin
            if (enable) begin
               if (w_legal) begin
                  index_d = w_idx;
                  valid_d = 1'b1;
                  pos_d   = '0;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         ST_TRACK: begin
            if (enable) begin
               if (!w_legal) begin
                  illegal_d = 1'b1;
                  seq_err_d = 1'b1;
                  valid_d   = 1'b0;
               end else if (w_fwd) begin
                  step_d  = 1'b1;
                  dir_d   = 1'b0;
                  pos_d   = pos_q + CNT_W'(1);
                  index_d = w_idx;
               end else if (w_bwd) begin
                  step_d  = 1'b1;
                  dir_d   = 1'b1;
                  pos_d   = pos_q - CNT_W'(1);
                  index_d = w_idx;
               end else if (!w_same) begin
                  seq_err_d = 1'b1;
                  valid_d   = 1'b0;
               end
            end
         end
         ST_ERR: begin
            if (enable && !w_legal) illegal_d = 1'b1;
            if (clear_err) begin
               seq_err_d = 1'b0;
               pos_d     = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         index_q   <= '0;
         valid_q   <= 1'b0;
         dir_q     <= 1'b0;
         step_q    <= 1'b0;
         illegal_q <= 1'b0;
         seq_err_q <= 1'b0;
         pos_q     <= '0;
      end else begin
         index_q   <= index_d;
         valid_q   <= valid_d;
         dir_q     <= dir_d;
         step_q    <= step_d;
         illegal_q <= illegal_d;
         seq_err_q <= seq_err_d;
         pos_q     <= pos_d;
      end
   end

   assign index_out = index_q;
   assign valid     = valid_q;
   assign dir       = dir_q;
   assign step      = step_q;
   assign illegal   = illegal_q;
   assign seq_err   = seq_err_q;
   assign position  = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_decode_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_decode_monitor
// Description : Scoreboard bench for johnson_decode_monitor (WIDTH=4, CNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_decode_monitor;

   logic       clock;
   logic       reset;
   logic       enable;
   logic       clear_err;
   logic [3:0] code_in;
   logic [2:0] index_out;
   logic       valid;
   logic       dir;
   logic       step;
   logic       illegal;
   logic       seq_err;
   logic [7:0] position;

   typedef struct {
      int         id;
      logic [2:0] idx;
      logic       v;
      logic       d;
      logic       s;
      logic       ill;
      logic       err;
      logic [7:0] pos;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   vec_id  = 0;

   johnson_decode_monitor #(
      .WIDTH (4),
      .CNT_W (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .clear_err (clear_err),
      .code_in   (code_in),
      .index_out (index_out),
      .valid     (valid),
      .dir       (dir),
      .step      (step),
      .illegal   (illegal),
      .seq_err   (seq_err),
      .position  (position)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec%0d: got %0h expected %0h", nm, id, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, "_index"},   e.id, 32'(index_out), 32'(e.idx));
      chk({tag, "_valid"},   e.id, 32'(valid),     32'(e.v));
      chk({tag, "_dir"},     e.id, 32'(dir),       32'(e.d));
      chk({tag, "_step"},    e.id, 32'(step),      32'(e.s));
      chk({tag, "_illegal"}, e.id, 32'(illegal),   32'(e.ill));
      chk({tag, "_seq_err"}, e.id, 32'(seq_err),   32'(e.err));
      chk({tag, "_pos"},     e.id, 32'(position),  32'(e.pos));
   endtask

   // Drive one sample and queue the outputs expected after the next edge.
   task automatic vec(input logic en, input logic clr, input logic [3:0] code,
                      input logic [2:0] idx, input logic v, input logic d, input logic s,
                      input logic ill, input logic err, input logic [7:0] pos);
      exp_t e;
      @(negedge clock);
      enable    = en;
      clear_err = clr;
      code_in   = code;
      vec_id++;
      e.id = vec_id; e.idx = idx; e.v = v; e.d = d; e.s = s;
      e.ill = ill; e.err = err; e.pos = pos;
      sb.push_back(e);
   endtask

   // Pulse the async reset between edges; optionally check outputs clear at once.
   task automatic do_reset(input bit check);
      exp_t z;
      @(negedge clock);
      enable    = 1'b0;
      clear_err = 1'b0;
      #2 reset = 1'b0;
      #1;
      if (check) begin
         z.id = -1; z.idx = '0; z.v = 1'b0; z.d = 1'b0; z.s = 1'b0;
         z.ill = 1'b0; z.err = 1'b0; z.pos = '0;
         chk_all("async_rst", z);
      end
      #1 reset = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_all("out", e);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      exp_t z;
      reset     = 1'b0;
      enable    = 1'b0;
      clear_err = 1'b0;
      code_in   = 4'b0000;
      repeat (2) @(negedge clock);
      z.id = 0; z.idx = '0; z.v = 1'b0; z.d = 1'b0; z.s = 1'b0;
      z.ill = 1'b0; z.err = 1'b0; z.pos = '0;
      chk_all("reset", z);
      reset = 1'b1;

      // Up walk through a full revolution, including the 7 -> 0 wrap
      //   en clr code      idx v d s i e pos
      vec(1, 0, 4'b0000, 3'd0, 1, 0, 0, 0, 0, 8'h00);
      vec(1, 0, 4'b0001, 3'd1, 1, 0, 1, 0, 0, 8'h01);
      vec(1, 0, 4'b0011, 3'd2, 1, 0, 1, 0, 0, 8'h02);
      vec(1, 0, 4'b0111, 3'd3, 1, 0, 1, 0, 0, 8'h03);
      vec(1, 0, 4'b1111, 3'd4, 1, 0, 1, 0, 0, 8'h04);
      vec(1, 0, 4'b1110, 3'd5, 1, 0, 1, 0, 0, 8'h05);
      vec(1, 0, 4'b1100, 3'd6, 1, 0, 1, 0, 0, 8'h06);
      vec(1, 0, 4'b1000, 3'd7, 1, 0, 1, 0, 0, 8'h07);
      vec(1, 0, 4'b0000, 3'd0, 1, 0, 1, 0, 0, 8'h08);
      vec(1, 0, 4'b0000, 3'd0, 1, 0, 0, 0, 0, 8'h08);

      // Down walk with 0 -> 7 wrap, then reverse, then enable-low hold
      do_reset(0);
      vec(1, 0, 4'b0000, 3'd0, 1, 0, 0, 0, 0, 8'h00);
      vec(1, 0, 4'b1000, 3'd7, 1, 1, 1, 0, 0, 8'hFF);
      vec(1, 0, 4'b1100, 3'd6, 1, 1, 1, 0, 0, 8'hFE);
      vec(1, 0, 4'b1110, 3'd5, 1, 1, 1, 0, 0, 8'hFD);
      vec(1, 0, 4'b1100, 3'd6, 1, 0, 1, 0, 0, 8'hFE);
      vec(0, 0, 4'b0101, 3'd6, 1, 0, 0, 0, 0, 8'hFE);
      vec(0, 0, 4'b1111, 3'd6, 1, 0, 0, 0, 0, 8'hFE);
      vec(1, 0, 4'b1100, 3'd6, 1, 0, 0, 0, 0, 8'hFE);

      // Illegal in TRACK, ERR behaviour, clear and re-acquire
      do_reset(0);
      vec(1, 0, 4'b0000, 3'd0, 1, 0, 0, 0, 0, 8'h00);
      vec(1, 0, 4'b0001, 3'd1, 1, 0, 1, 0, 0, 8'h01);
      vec(1, 0, 4'b0011, 3'd2, 1, 0, 1, 0, 0, 8'h02);
      vec(1, 0, 4'b0101, 3'd2, 0, 0, 0, 1, 1, 8'h02);
      vec(1, 0, 4'b0111, 3'd2, 0, 0, 0, 0, 1, 8'h02);
      vec(1, 0, 4'b1010, 3'd2, 0, 0, 0, 1, 1, 8'h02);
      vec(1, 1, 4'b0111, 3'd2, 0, 0, 0, 0, 0, 8'h00);
      vec(1, 0, 4'b0111, 3'd3, 1, 0, 0, 0, 0, 8'h00);
      vec(1, 0, 4'b1111, 3'd4, 1, 0, 1, 0, 0, 8'h01);
      vec(1, 1, 4'b1111, 3'd4, 1, 0, 0, 0, 0, 8'h01);
      // Skip of two from TRACK
      vec(1, 0, 4'b1100, 3'd4, 0, 0, 0, 0, 1, 8'h01);
      vec(1, 1, 4'b0001, 3'd4, 0, 0, 0, 0, 0, 8'h00);
      vec(1, 0, 4'b0001, 3'd1, 1, 0, 0, 0, 0, 8'h00);
      // Skip with clear_err in the same cycle: the error wins, then ERR ignores a +1
      vec(1, 1, 4'b0111, 3'd1, 0, 0, 0, 0, 1, 8'h00);
      vec(1, 0, 4'b0011, 3'd1, 0, 0, 0, 0, 1, 8'h00);
      vec(1, 1, 4'b0011, 3'd1, 0, 0, 0, 0, 0, 8'h00);
      // Illegal in INIT pulses but does not set seq_err
      vec(1, 0, 4'b1011, 3'd1, 0, 0, 0, 1, 0, 8'h00);
      vec(1, 0, 4'b0000, 3'd0, 1, 0, 0, 0, 0, 8'h00);
      vec(1, 0, 4'b0001, 3'd1, 1, 0, 1, 0, 0, 8'h01);

      // Async reset mid-walk, then re-acquire
      do_reset(1);
      vec(1, 0, 4'b0011, 3'd2, 1, 0, 0, 0, 0, 8'h00);
      vec(1, 0, 4'b0111, 3'd3, 1, 0, 1, 0, 0, 8'h01);

      repeat (3) @(negedge clock);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
